sb_bank_fill_ctrl: RTL and testbench
====================================

// Module: sb_bank_fill_ctrl
// PURPOSE
//  System-bus slave fronting NUM_BANKS 32-bit sync-read memory banks (char map, colour map, font, ...).
//  Decodes the bank from the address, registers read data (1-cycle latency) and drives shared bank ports.
//  Adds a hardware fill engine that writes one pattern word to every location of a selected bank
//  (clear-screen), one word per cycle, with bus stall and a pollable status CSR.
// PARAMETERS
//  NUM_BANKS     3   number of attached banks (1..7)
//  BANK_AW       10  word-address width per bank; bank depth = 2**BANK_AW words
//  BANK_SEL_LSB  12  lowest address bit of the bank-select field; must be >= BANK_AW+2
// PORTS
//  clk_i           in   1               system clock; the only clock
//  rst_i           in   1               reset, synchronous, active-low
//  req_i           in   1               bus request
//  write_enable_i  in   1               1 = write, 0 = read
//  mem_be_i        in   4               byte enables
//  addr_i          in   32              byte address
//  write_data_i    in   32              write data
//  ready_o         out  1               request accepted this cycle when req_i & ready_o
//  read_data_o     out  32              read data, valid when rvalid_o
//  rvalid_o        out  1               one-cycle pulse, read data valid
//  bank_we_o       out  NUM_BANKS       per-bank write strobe (one-hot or zero)
//  bank_addr_o     out  BANK_AW         shared bank word address
//  bank_be_o       out  4               shared bank byte enables
//  bank_wdata_o    out  32              shared bank write data
//  bank_rdata_i    in   NUM_BANKS*32    bank read data; bank b at [32*b +: 32], valid 1 cycle after address
// BEHAVIOUR
//  Decode: sel = addr_i[BANK_SEL_LSB +: clog2(NUM_BANKS+1)], word = addr_i[BANK_AW+1:2].
//   sel < NUM_BANKS -> bank sel; sel == NUM_BANKS -> CSR space; otherwise unmapped.
//  CSRs (word offset): 0 FILL_CTRL: wr bit31=start, bits[2:0]=bank id; rd returns last written bank id.
//   1 FILL_DATA: rd/wr pattern, honours mem_be_i. 2 STATUS: bit0 busy, bit1 done (sticky),
//   bit2 err (sticky); writing 1 to bit1/bit2 clears that bit. FILL_CTRL/STATUS writes ignore mem_be_i.
//  Reset (rst_i==0 at a clk_i edge): FSM->IDLE, counter=0, FILL_DATA=0, bank id=0, status=0,
//   read_data_o=0, rvalid_o=0, bank_we_o=0. Reset mid-fill aborts; remaining words stay untouched.
//  Bank ports are combinational from bus inputs in IDLE; from fill engine in FILL.
//  ready_o: 1 in IDLE; in FILL 1 only for CSR/unmapped addresses, 0 for any bank address.
//  Accepted bank write: bank_we_o[sel]=1 same cycle, be/wdata passed through.
//  Accepted read: rvalid_o=1 next cycle; read_data_o = bank_rdata_i[sel] (sel registered), CSR value
//   registered at accept, or 0 if unmapped. Unmapped writes ignored, still accepted.
//  FSM IDLE: CSR write start=1 with bank id < NUM_BANKS -> FILL, counter=0, busy=1, done cleared.
//   start with bank id >= NUM_BANKS -> stay IDLE, err=1. start while FILL ignored (no err).
//  FSM FILL: each cycle bank_we_o[id]=1, addr=counter, be=4'hF, wdata=FILL_DATA captured at start.
//   counter == 2**BANK_AW-1 -> IDLE next cycle, busy=0, done=1. Fill takes exactly 2**BANK_AW cycles.
//   FILL_DATA writes during FILL update the CSR only, not the running fill.
//  Same-cycle STATUS write-1-clear and fill completion: completion wins (done=1).
//  rvalid_o never asserted for writes; back-to-back reads give back-to-back rvalid_o.
// TESTING (NUM_BANKS=3, BANK_AW=10, BANK_SEL_LSB=12; CSR base 0x3000)
//  Read 0x1008 with bank1 word2 = 0xCAFE0001 -> ready_o=1, next cycle rvalid_o=1, read_data_o=0xCAFE0001.
//  Write 0x0004 data 0x11223344 be=4'b0011 -> bank_we_o=3'b001, bank_addr_o=1, bank_be_o=4'b0011 same cycle.
//  Write 0x3004=0xA5A5A5A5, 0x3000=0x80000002 -> 1024 cycles bank_we_o=3'b100, addr 0..1023,
//   then STATUS reads 0x2; bank2 all 0xA5A5A5A5.
//  During fill: read 0x0000 -> ready_o=0 until fill ends; read 0x3008 -> accepted, bit0=1.
//  Write 0x3000=0x80000005 -> no fill, STATUS=0x4; write 0x3008=0x4 -> STATUS=0x0.
//  Drop rst_i at fill word 500 -> next cycle bank_we_o=0, STATUS=0; read 0x7000 -> rvalid_o=1, data 0.

Source files
------------

// File: rtl/sb_bank_fill_ctrl.sv
// Bus slave in front of NUM_BANKS sync-read memory banks, with a hardware fill engine
// that writes one pattern word to every location of a chosen bank and a small CSR block.
module sb_bank_fill_ctrl #(
   parameter int NUM_BANKS    = 3,
   parameter int BANK_AW      = 10,
   parameter int BANK_SEL_LSB = 12
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic                    write_enable_i,
   input  logic [3:0]              mem_be_i,
   input  logic [31:0]             addr_i,
   input  logic [31:0]             write_data_i,
   output logic                    ready_o,
   output logic [31:0]             read_data_o,
   output logic                    rvalid_o,
   output logic [NUM_BANKS-1:0]    bank_we_o,
   output logic [BANK_AW-1:0]      bank_addr_o,
   output logic [3:0]              bank_be_o,
   output logic [31:0]             bank_wdata_o,
   input  logic [NUM_BANKS*32-1:0] bank_rdata_i
);

   localparam int SEL_W = $clog2(NUM_BANKS + 1);
   localparam logic [BANK_AW-1:0] LAST_WORD = '1;
   localparam logic [BANK_AW-1:0] CSR_CTRL  = BANK_AW'(0);
   localparam logic [BANK_AW-1:0] CSR_DATA  = BANK_AW'(1);
   localparam logic [BANK_AW-1:0] CSR_STAT  = BANK_AW'(2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [BANK_AW-1:0] cnt_q, cnt_d;
   logic [2:0]         fill_bank_q, fill_bank_d;
   logic [31:0]        pattern_q, pattern_d;
   logic [31:0]        fill_data_q, fill_data_d;
   logic [2:0]         bank_id_q, bank_id_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               rvalid_q;
   logic               rd_bank_q;
   logic [SEL_W-1:0]   rd_sel_q;
   logic [31:0]        rd_csr_q;

   logic [SEL_W-1:0]   sel;
   logic [BANK_AW-1:0] word;
   logic               is_bank, is_csr;
   logic               accept, wr_acc, rd_acc, bank_wr;
   logic               ctrl_wr, data_wr, stat_wr;
   logic               start_req, start_ok;
   logic [31:0]        csr_rdata;
   logic [31:0]        bank_rd;
   logic               unused_addr;

   assign sel         = addr_i[BANK_SEL_LSB +: SEL_W];
   assign word        = addr_i[BANK_AW+1:2];
   assign is_bank     = int'(sel) < NUM_BANKS;
   assign is_csr      = int'(sel) == NUM_BANKS;
   assign unused_addr = ^addr_i;

   // Handshake: a request transfers on any cycle where req_i && ready_o; reads answer with a
   // single rvalid_o pulse on the following cycle, writes never produce rvalid_o.
   assign ready_o = (state_q == ST_IDLE) || !is_bank;
   assign accept  = req_i && ready_o;
   assign wr_acc  = accept && write_enable_i;
   assign rd_acc  = accept && !write_enable_i;
   assign bank_wr = wr_acc && is_bank;

   assign ctrl_wr   = wr_acc && is_csr && (word == CSR_CTRL);
   assign data_wr   = wr_acc && is_csr && (word == CSR_DATA);
   assign stat_wr   = wr_acc && is_csr && (word == CSR_STAT);
   assign start_req = ctrl_wr && write_data_i[31];
   assign start_ok  = start_req && (int'(write_data_i[2:0]) < NUM_BANKS);

   always_comb begin
      csr_rdata = '0;
      case (word)
         CSR_CTRL: csr_rdata = {29'd0, bank_id_q};
         CSR_DATA: csr_rdata = fill_data_q;
         CSR_STAT: csr_rdata = {29'd0, err_q, done_q, state_q == ST_FILL};
         default:  csr_rdata = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_bank_d = fill_bank_q;
      pattern_d   = pattern_q;
      fill_data_d = fill_data_q;
      bank_id_d   = bank_id_q;
      done_d      = done_q;
      err_d       = err_q;

      if (ctrl_wr) bank_id_d = write_data_i[2:0];
      for (int k = 0; k < 4; k++) begin
         if (data_wr && mem_be_i[k]) fill_data_d[8*k +: 8] = write_data_i[8*k +: 8];
      end
      if (stat_wr && write_data_i[1]) done_d = 1'b0;
      if (stat_wr && write_data_i[2]) err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d     = ST_FILL;
               cnt_d       = '0;
               fill_bank_d = write_data_i[2:0];
               pattern_d   = fill_data_q;
               done_d      = 1'b0;
            end else if (start_req) begin
               err_d = 1'b1;
            end
         end
         ST_FILL: begin
            cnt_d = cnt_q + 1'b1;
            // Completion is applied after the write-1-clear so it wins on a collision.
            if (cnt_q == LAST_WORD) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bank_we_o    = '0;
      bank_addr_o  = word;
      bank_be_o    = mem_be_i;
      bank_wdata_o = write_data_i;
      if (state_q == ST_FILL) begin
         bank_addr_o  = cnt_q;
         bank_be_o    = 4'hF;
         bank_wdata_o = pattern_q;
         for (int b = 0; b < NUM_BANKS; b++) bank_we_o[b] = int'(fill_bank_q) == b;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) bank_we_o[b] = bank_wr && (int'(sel) == b);
      end
   end

   always_comb begin
      bank_rd = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (int'(rd_sel_q) == b) bank_rd = bank_rdata_i[32*b +: 32];
      end
   end

   assign rvalid_o    = rvalid_q;
   assign read_data_o = !rvalid_q ? 32'd0 : (rd_bank_q ? bank_rd : rd_csr_q);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         fill_bank_q <= '0;
         pattern_q   <= '0;
         fill_data_q <= '0;
         bank_id_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_sel_q    <= '0;
         rd_csr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_bank_q <= fill_bank_d;
         pattern_q   <= pattern_d;
         fill_data_q <= fill_data_d;
         bank_id_q   <= bank_id_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rvalid_q    <= rd_acc;
         if (rd_acc) begin
            rd_bank_q <= is_bank;
            rd_sel_q  <= sel;
            rd_csr_q  <= is_csr ? csr_rdata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_sb_bank_fill_ctrl.sv
// Bench for sb_bank_fill_ctrl: behavioural bank/CSR model, per-cycle output compare,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_sb_bank_fill_ctrl;

   localparam int NB    = 3;
   localparam int AW    = 10;
   localparam int LSB   = 12;
   localparam int DEPTH = 1 << AW;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            req_i = 1'b0;
   logic            write_enable_i = 1'b0;
   logic [3:0]      mem_be_i = 4'h0;
   logic [31:0]     addr_i = 32'h0;
   logic [31:0]     write_data_i = 32'h0;
   logic            ready_o;
   logic [31:0]     read_data_o;
   logic            rvalid_o;
   logic [NB-1:0]   bank_we_o;
   logic [AW-1:0]   bank_addr_o;
   logic [3:0]      bank_be_o;
   logic [31:0]     bank_wdata_o;
   logic [NB*32-1:0] bank_rdata_i;

   sb_bank_fill_ctrl #(.NUM_BANKS(NB), .BANK_AW(AW), .BANK_SEL_LSB(LSB)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_enable_i(write_enable_i),
      .mem_be_i(mem_be_i), .addr_i(addr_i), .write_data_i(write_data_i),
      .ready_o(ready_o), .read_data_o(read_data_o), .rvalid_o(rvalid_o),
      .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o), .bank_be_o(bank_be_o),
      .bank_wdata_o(bank_wdata_o), .bank_rdata_i(bank_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Physical banks attached to the DUT: byte-enabled write, one-cycle read.
   logic [31:0] bank_mem [NB][DEPTH];
   logic [31:0] init_mem [NB][DEPTH];
   logic [31:0] rdata_r  [NB];

   always @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         for (int k = 0; k < 4; k++) begin
            if (bank_we_o[b] && bank_be_o[k]) bank_mem[b][bank_addr_o][8*k +: 8] <= bank_wdata_o[8*k +: 8];
         end
         rdata_r[b] <= bank_mem[b][bank_addr_o];
      end
   end
   assign bank_rdata_i = {rdata_r[2], rdata_r[1], rdata_r[0]};

   // Reference model: what the banks should hold and what the bus should see.
   logic [31:0] ref_mem [NB][DEPTH];
   bit          m_fill, m_done, m_err, m_rvalid;
   int          m_pos, m_bank, m_id;
   logic [31:0] m_pat, m_fdata, m_rdata;

   function automatic int sel_of(input logic [31:0] a);
      return int'((a >> LSB) & 32'h3);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) & (DEPTH - 1));
   endfunction

   function automatic bit m_ready();
      return !m_fill || (sel_of(addr_i) >= NB);
   endfunction

   always @(posedge clk_i) begin
      int s, w;
      bit acc, wf;
      logic [31:0] csr_v;
      s   = sel_of(addr_i);
      w   = word_of(addr_i);
      acc = req_i && m_ready();
      wf  = m_fill;
      if (wf) ref_mem[m_bank][m_pos] = m_pat;
      else if (acc && write_enable_i && s < NB) begin
         for (int k = 0; k < 4; k++) if (mem_be_i[k]) ref_mem[s][w][8*k +: 8] = write_data_i[8*k +: 8];
      end
      if (!rst_i) begin
         m_fill = 0; m_done = 0; m_err = 0; m_rvalid = 0;
         m_pos = 0; m_bank = 0; m_id = 0; m_pat = 0; m_fdata = 0; m_rdata = 0;
      end else begin
         csr_v = 32'h0;
         if (s == NB) begin
            if (w == 0) csr_v = m_id;
            else if (w == 1) csr_v = m_fdata;
            else if (w == 2) csr_v = {29'd0, m_err, m_done, wf};
         end
         m_rvalid = acc && !write_enable_i;
         if (m_rvalid) m_rdata = (s < NB) ? ref_mem[s][w] : csr_v;
         if (wf) m_pos++;
         if (acc && write_enable_i && s == NB) begin
            if (w == 0) begin
               m_id = int'(write_data_i[2:0]);
               if (write_data_i[31] && !wf) begin
                  if (m_id < NB) begin
                     m_fill = 1; m_pos = 0; m_bank = m_id; m_pat = m_fdata; m_done = 0;
                  end else m_err = 1;
               end
            end else if (w == 1) begin
               for (int k = 0; k < 4; k++) if (mem_be_i[k]) m_fdata[8*k +: 8] = write_data_i[8*k +: 8];
            end else if (w == 2) begin
               if (write_data_i[1]) m_done = 0;
               if (write_data_i[2]) m_err = 0;
            end
         end
         if (wf && m_pos == DEPTH) begin
            m_fill = 0; m_done = 1;
         end
      end
   end

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk_i) begin
      logic [31:0] ew, ea, ebe, ewd;
      int s;
      if (check_en) begin
         s = sel_of(addr_i);
         if (m_fill) begin
            ew = 32'(1) << m_bank; ea = m_pos; ebe = 32'hF; ewd = m_pat;
         end else begin
            ew  = (req_i && write_enable_i && s < NB) ? (32'(1) << s) : 32'h0;
            ea  = word_of(addr_i); ebe = {28'd0, mem_be_i}; ewd = write_data_i;
         end
         chk("ready", {31'd0, ready_o}, {31'd0, m_ready()});
         chk("bank_we", {29'd0, bank_we_o}, ew);
         chk("bank_addr", {22'd0, bank_addr_o}, ea);
         if (ew != 0) begin
            chk("bank_be", {28'd0, bank_be_o}, ebe);
            chk("bank_wdata", bank_wdata_o, ewd);
         end
         chk("rvalid", {31'd0, rvalid_o}, {31'd0, m_rvalid});
         if (m_rvalid) chk("read_data", read_data_o, m_rdata);
      end
   end

   task automatic bus_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd);
      int n;
      bit acc;
      req_i = 1'b1; write_enable_i = we; addr_i = a; write_data_i = d; mem_be_i = be;
      n = 0; acc = 0; rd = 32'h0;
      while (!acc && n < 3000) begin
         @(negedge clk_i);
         acc = ready_o;
         @(posedge clk_i); #2;
         n++;
      end
      req_i = 1'b0; write_enable_i = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL accept_timeout: addr %h never accepted within %0d cycles", a, n);
      end else if (!we) begin
         @(negedge clk_i);
         rd = read_data_o;
         @(posedge clk_i); #2;
      end
   endtask

   task automatic wait_pos(input int p);
      int n;
      n = 0;
      while (!(m_fill && m_pos == p) && n < 3000) begin
         @(posedge clk_i); #2;
         n++;
      end
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL fill_pos_timeout: word %0d never reached", p);
      end
   endtask

   initial begin
      logic [31:0] rd, v;
      int nbad;
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            if (b == 1 && i == 2) v = 32'hCAFE0001;
            bank_mem[b][i] = v; ref_mem[b][i] = v; init_mem[b][i] = v;
         end
      end
      @(posedge clk_i); #2;
      check_en = 1'b1;
      repeat (2) @(posedge clk_i);
      #2 rst_i = 1'b1;
      @(negedge clk_i);
      chk("reset_we", {29'd0, bank_we_o}, 32'h0);
      chk("reset_rvalid", {31'd0, rvalid_o}, 32'h0);
      chk("reset_rdata", read_data_o, 32'h0);
      chk("reset_ready", {31'd0, ready_o}, 32'h1);
      @(posedge clk_i); #2;

      bus_op(0, 32'h1008, 32'h0, 4'hF, rd);
      chk("read_bank1_w2", rd, 32'hCAFE0001);

      req_i = 1; write_enable_i = 1; addr_i = 32'h0004; write_data_i = 32'h11223344; mem_be_i = 4'b0011;
      @(negedge clk_i);
      chk("wr_we", {29'd0, bank_we_o}, 32'h1);
      chk("wr_addr", {22'd0, bank_addr_o}, 32'h1);
      chk("wr_be", {28'd0, bank_be_o}, 32'h3);
      @(posedge clk_i); #2;
      req_i = 0; write_enable_i = 0;

      bus_op(1, 32'h3004, 32'hA5A5A5A5, 4'hF, rd);
      bus_op(1, 32'h3000, 32'h80000002, 4'hF, rd);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_i);
         chk("fill_we", {29'd0, bank_we_o}, 32'h4);
         chk("fill_addr", {22'd0, bank_addr_o}, i);
         @(posedge clk_i); #2;
      end
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("status_done", rd, 32'h2);
      nbad = 0;
      for (int i = 0; i < DEPTH; i++) if (bank_mem[2][i] !== 32'hA5A5A5A5) nbad++;
      chk("bank2_filled", nbad, 0);

      bus_op(1, 32'h3004, 32'h5A5A0F0F, 4'hF, rd);
      bus_op(1, 32'h3000, 32'h80000000, 4'hF, rd);
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("status_busy", rd, 32'h1);
      bus_op(0, 32'h0000, 32'h0, 4'hF, rd);
      chk("stalled_read", rd, 32'h5A5A0F0F);
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("status_done2", rd, 32'h2);

      bus_op(1, 32'h3000, 32'h80000000, 4'hF, rd);
      wait_pos(DEPTH - 1);
      req_i = 1; write_enable_i = 1; addr_i = 32'h3008; write_data_i = 32'h2; mem_be_i = 4'hF;
      @(posedge clk_i); #2;
      req_i = 0; write_enable_i = 0;
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("done_beats_clear", rd, 32'h2);

      bus_op(1, 32'h3008, 32'h2, 4'hF, rd);
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("status_cleared", rd, 32'h0);
      bus_op(1, 32'h3000, 32'h80000005, 4'hF, rd);
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("status_err", rd, 32'h4);
      bus_op(0, 32'h3000, 32'h0, 4'hF, rd);
      chk("ctrl_bank_id", rd, 32'h5);
      bus_op(1, 32'h3008, 32'h4, 4'hF, rd);
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("err_cleared", rd, 32'h0);
      bus_op(1, 32'h3004, 32'hDEADBEEF, 4'b0101, rd);
      bus_op(0, 32'h3004, 32'h0, 4'hF, rd);
      chk("fill_data_be", rd, 32'h5AAD0FEF);

      bus_op(1, 32'h3000, 32'h80000001, 4'hF, rd);
      wait_pos(500);
      rst_i = 1'b0;
      @(posedge clk_i); #2;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("abort_we", {29'd0, bank_we_o}, 32'h0);
      @(posedge clk_i); #2;
      bus_op(0, 32'h3008, 32'h0, 4'hF, rd);
      chk("abort_status", rd, 32'h0);
      bus_op(0, 32'h7000, 32'h0, 4'hF, rd);
      chk("read_7000", rd, 32'h0);
      chk("abort_w499", bank_mem[1][499], 32'h5AAD0FEF);
      chk("abort_w600", bank_mem[1][600], init_mem[1][600]);

      for (int n = 0; n < 400; n++) begin
         int kind;
         logic [31:0] a, d;
         kind = $urandom_range(0, 9);
         d = $urandom;
         if (kind <= 5) begin
            a = (32'($urandom_range(0, NB - 1)) << LSB) | (32'($urandom_range(0, 15)) << 2);
            bus_op($urandom_range(0, 1), a, d, 4'($urandom_range(0, 15)), rd);
         end else if (kind <= 8) begin
            a = (32'(NB) << LSB) | (32'($urandom_range(0, 3)) << 2);
            if (a[3:2] == 2'd0) d = {($urandom_range(0, 5) == 0), 28'd0, 3'($urandom_range(0, 7))};
            bus_op($urandom_range(0, 1), a, d, 4'($urandom_range(0, 15)), rd);
         end else begin
            @(posedge clk_i); #2;
         end
      end
      while (m_fill) begin
         @(posedge clk_i); #2;
      end
      @(posedge clk_i); #2;

      for (int b = 0; b < NB; b++) begin
         nbad = 0;
         for (int i = 0; i < DEPTH; i++) if (bank_mem[b][i] !== ref_mem[b][i]) nbad++;
         chk("bank_contents", nbad, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
